// File: rtl/serial_add_unit.sv
// Bit-serial LSB-first adder: one full-add slice plus a carry flop, WIDTH+1 cycles per result.
// Define SERIAL_ADD_OVF_EN to register signed overflow; otherwise ovf is tied low.
module serial_add_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | one bit added per cycle, LSB first
  // DONE  | result valid, done pulse; start here chains the next operation
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   r_sh_q, r_sh_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic s_bit;
  logic c_new;
  logic last_bit;
  logic accept;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    c_new    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    accept   = start && (state_q != ST_SHIFT);

    case (state_q)
      ST_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_sh_d = {s_bit, r_sh_q[WIDTH-1:1]};
        c_d    = c_new;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = ST_DONE;
          sum_d   = {s_bit, r_sh_q[WIDTH-1:1]};
          cout_d  = c_new;
`ifdef SERIAL_ADD_OVF_EN
          // c_q is the carry into the MSB slice on this last cycle
          ovf_d   = c_q ^ c_new;
`endif
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d = ST_SHIFT;
      a_sh_d  = a_in;
      b_sh_d  = b_in;
      c_d     = cin;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule
